// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for the 4-digit multiplexed 7-segment scan driver.
// The master drives the digit data and display options; the slave (the driver) returns the
// anode, cathode and frame strobes.
interface seg7_scan_driver_if;
  logic [15:0] digit_in;
  logic        load;
  logic        blank_lz;
  logic        dp_en;
  logic [1:0]  dp_pos;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  modport master (
    output digit_in, load, blank_lz, dp_en, dp_pos,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  digit_in, load, blank_lz, dp_en, dp_pos,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with a ghost-guard blank window, leading-zero
// blanking, a decimal point, and a shadow/active register pair.
// Digit data only reaches the display on slot boundaries, so a digit never changes mid-slot.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 4
) (
  input logic              clk,
  input logic              rst,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned CntW = 16;

  typedef enum logic [1:0] {StDig0, StDig1, StDig2, StDig3} idx_e;

  logic [CntW-1:0] scan_cnt_q, scan_cnt_d;
  idx_e            idx_q, idx_d;
  logic [15:0]     shadow_q, active_q;
  logic            slot_end;

  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            frame_done_q, frame_done_d;

  // >= rather than == so an out-of-range count still wraps instead of running away.
  assign slot_end = (scan_cnt_q >= CntW'(SCAN_DIV - 1));

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
    logic [6:0] s;
    unique case (code)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111; // non-BCD codes show a dash
    endcase
    return s;
  endfunction

  // Prescaler and digit-index next state; idx only moves on a slot boundary.
  always_comb begin
    scan_cnt_d = slot_end ? '0 : scan_cnt_q + CntW'(1);
    idx_d      = idx_q;
    if (slot_end) begin
      unique case (idx_q)
        StDig0:  idx_d = StDig1;
        StDig1:  idx_d = StDig2;
        StDig2:  idx_d = StDig3;
        StDig3:  idx_d = StDig0;
        default: idx_d = StDig0;
      endcase
    end
  end

  // Scan state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= StDig0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
    end
  end

  // Shadow captures every load; active follows on the boundary, bypassing on a coincident load.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (bus.load) begin
        shadow_q <= bus.digit_in;
      end
      if (slot_end) begin
        active_q <= bus.load ? bus.digit_in : shadow_q;
      end
    end
  end

  // Output decode from the current scan position and active digits.
  always_comb begin
    logic [3:0] cur_digit;
    logic       z3, z2, z1;
    logic       lz_blank;

    an_d         = 4'b1111;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    frame_done_d = slot_end && (idx_q == StDig3);

    // A digit is a leading zero only if it and every higher digit are zero.
    z3 = (active_q[15:12] == 4'd0);
    z2 = z3 && (active_q[11:8] == 4'd0);
    z1 = z2 && (active_q[7:4] == 4'd0);

    cur_digit = active_q[3:0];
    lz_blank  = 1'b0;
    unique case (idx_q)
      StDig0: begin
        cur_digit = active_q[3:0];
        lz_blank  = 1'b0;
      end
      StDig1: begin
        cur_digit = active_q[7:4];
        lz_blank  = z1;
      end
      StDig2: begin
        cur_digit = active_q[11:8];
        lz_blank  = z2;
      end
      StDig3: begin
        cur_digit = active_q[15:12];
        lz_blank  = z3;
      end
      default: begin
        cur_digit = active_q[3:0];
        lz_blank  = 1'b0;
      end
    endcase

    if (scan_cnt_q >= CntW'(BLANK_CYC)) begin
      an_d[idx_q] = 1'b0;
      seg_d       = (bus.blank_lz && lz_blank) ? 7'h7F : bcd_to_seg(cur_digit);
      // The decimal point survives leading-zero blanking.
      dp_d        = ~(bus.dp_en && (2'(idx_q) == bus.dp_pos));
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=8, BLANK_CYC=2.
// cyc counts rising edges since reset release (edge 0 is the first non-reset edge); after
// edge n the outputs reflect scan_cnt = n%8 and idx = (n/8)%4.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst;
  int   cyc;
  int   checks = 0;
  int   errors = 0;

  seg7_scan_driver_if bus_if ();

  seg7_scan_driver #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                     input logic e_dp);
    checks++;
    assert (bus_if.an === e_an) else begin
      errors++;
      $error("FAIL %s an: got %b expected %b (cyc %0d)", tag, bus_if.an, e_an, cyc);
    end
    checks++;
    assert (bus_if.seg === e_seg) else begin
      errors++;
      $error("FAIL %s seg: got %b expected %b (cyc %0d)", tag, bus_if.seg, e_seg, cyc);
    end
    checks++;
    assert (bus_if.dp === e_dp) else begin
      errors++;
      $error("FAIL %s dp: got %b expected %b (cyc %0d)", tag, bus_if.dp, e_dp, cyc);
    end
  endtask

  task automatic chk_fd(input string tag, input logic e_fd);
    checks++;
    assert (bus_if.frame_done === e_fd) else begin
      errors++;
      $error("FAIL %s frame_done: got %b expected %b (cyc %0d)", tag, bus_if.frame_done, e_fd,
             cyc);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus_if.digit_in = 16'h0000;
    bus_if.load     = 1'b0;
    bus_if.blank_lz = 1'b0;
    bus_if.dp_en    = 1'b0;
    bus_if.dp_pos   = 2'd0;
    cyc             = 0;

    // Reset values.
    tick(); tick(); tick();
    chk("reset", 4'hF, 7'h7F, 1'b1);
    chk_fd("reset", 1'b0);

    // Release: first lit anode three edges after the last reset edge.
    rst = 1'b0;
    cyc = -1;
    wait_cyc(0);  chk("rel_c0", 4'hF, 7'h7F, 1'b1);
    wait_cyc(1);  chk("rel_c1", 4'hF, 7'h7F, 1'b1);
    wait_cyc(2);  chk("d0_zero", 4'b1110, 7'b1000000, 1'b1);
    wait_cyc(7);  chk("d0_end", 4'b1110, 7'b1000000, 1'b1);
    wait_cyc(8);  chk("d1_blank", 4'hF, 7'h7F, 1'b1);
    wait_cyc(10); chk("d1_zero", 4'b1101, 7'b1000000, 1'b1);
    wait_cyc(18); chk("d2_zero", 4'b1011, 7'b1000000, 1'b1);
    wait_cyc(26); chk("d3_zero", 4'b0111, 7'b1000000, 1'b1);
    wait_cyc(30); chk_fd("fd_before", 1'b0);
    wait_cyc(31); chk_fd("fd_pulse0", 1'b1);
    wait_cyc(32); chk_fd("fd_after", 1'b0);
    wait_cyc(34); chk("d0_wrap", 4'b1110, 7'b1000000, 1'b1);

    // Mid-slot load of 1234: current digit holds until the boundary.
    wait_cyc(36);
    bus_if.digit_in = 16'h1234;
    bus_if.load     = 1'b1;
    wait_cyc(37);
    bus_if.load = 1'b0;
    chk("ld_hold_a", 4'b1110, 7'b1000000, 1'b1);
    wait_cyc(39); chk("ld_hold_b", 4'b1110, 7'b1000000, 1'b1);
    wait_cyc(42); chk("ld_d1_3", 4'b1101, 7'b0110000, 1'b1);
    wait_cyc(50); chk("ld_d2_2", 4'b1011, 7'b0100100, 1'b1);
    wait_cyc(58); chk("ld_d3_1", 4'b0111, 7'b1111001, 1'b1);
    wait_cyc(63); chk_fd("fd_pulse1", 1'b1);
    wait_cyc(66); chk("fr_d0_4", 4'b1110, 7'b0011001, 1'b1);
    wait_cyc(74); chk("fr_d1_3", 4'b1101, 7'b0110000, 1'b1);
    wait_cyc(82); chk("fr_d2_2", 4'b1011, 7'b0100100, 1'b1);
    wait_cyc(90); chk("fr_d3_1", 4'b0111, 7'b1111001, 1'b1);

    // 0050 with leading-zero blanking.
    wait_cyc(92);
    bus_if.digit_in = 16'h0050;
    bus_if.load     = 1'b1;
    bus_if.blank_lz = 1'b1;
    wait_cyc(93);
    bus_if.load = 1'b0;
    wait_cyc(98);  chk("lz_d0_0", 4'b1110, 7'b1000000, 1'b1);
    wait_cyc(106); chk("lz_d1_5", 4'b1101, 7'b0010010, 1'b1);
    wait_cyc(114); chk("lz_d2_blk", 4'b1011, 7'h7F, 1'b1);
    wait_cyc(122); chk("lz_d3_blk", 4'b0111, 7'h7F, 1'b1);
    bus_if.blank_lz = 1'b0;
    wait_cyc(123); chk("nolz_d3", 4'b0111, 7'b1000000, 1'b1);
    wait_cyc(146); chk("nolz_d2", 4'b1011, 7'b1000000, 1'b1);

    // 00A0: dash is nonzero and stops blanking.
    wait_cyc(148);
    bus_if.digit_in = 16'h00A0;
    bus_if.load     = 1'b1;
    bus_if.blank_lz = 1'b1;
    wait_cyc(149);
    bus_if.load = 1'b0;
    wait_cyc(162); chk("dash_d0", 4'b1110, 7'b1000000, 1'b1);
    wait_cyc(170); chk("dash_d1", 4'b1101, 7'b0111111, 1'b1);
    wait_cyc(178); chk("dash_d2", 4'b1011, 7'h7F, 1'b1);
    wait_cyc(186); chk("dash_d3", 4'b0111, 7'h7F, 1'b1);

    // Decimal point on digit 2, not suppressed by leading-zero blanking.
    bus_if.dp_en  = 1'b1;
    bus_if.dp_pos = 2'd2;
    wait_cyc(202); chk("dp_d1", 4'b1101, 7'b0111111, 1'b1);
    wait_cyc(208); chk("dp_d2_blank", 4'hF, 7'h7F, 1'b1);
    wait_cyc(210); chk("dp_d2_on", 4'b1011, 7'h7F, 1'b0);
    wait_cyc(215); chk("dp_d2_end", 4'b1011, 7'h7F, 1'b0);
    wait_cyc(216); chk("dp_d3_blank", 4'hF, 7'h7F, 1'b1);
    wait_cyc(218); chk("dp_d3", 4'b0111, 7'h7F, 1'b1);
    wait_cyc(222); chk_fd("fd_pre2", 1'b0);
    wait_cyc(223); chk_fd("fd_pulse2", 1'b1);
    wait_cyc(224); chk_fd("fd_post2", 1'b0);

    // Load on a boundary edge (edge 231): active takes 9999 directly.
    wait_cyc(230);
    bus_if.dp_en    = 1'b0;
    bus_if.blank_lz = 1'b0;
    bus_if.digit_in = 16'h9999;
    bus_if.load     = 1'b1;
    wait_cyc(231);
    bus_if.load = 1'b0;
    chk("bnd_old", 4'b1110, 7'b1000000, 1'b1);
    wait_cyc(234); chk("bnd_d1_9", 4'b1101, 7'b0010000, 1'b1);

    // Mid-slot reset with a concurrent load: reset must win.
    rst             = 1'b1;
    bus_if.digit_in = 16'h1234;
    bus_if.load     = 1'b1;
    wait_cyc(235);
    chk("rst_mid", 4'hF, 7'h7F, 1'b1);
    chk_fd("rst_mid", 1'b0);
    wait_cyc(236);
    chk("rst_mid2", 4'hF, 7'h7F, 1'b1);
    rst         = 1'b0;
    bus_if.load = 1'b0;
    cyc         = -1;
    wait_cyc(0);  chk("rst2_c0", 4'hF, 7'h7F, 1'b1);
    wait_cyc(1);  chk("rst2_c1", 4'hF, 7'h7F, 1'b1);
    wait_cyc(2);  chk("rst2_d0", 4'b1110, 7'b1000000, 1'b1);
    wait_cyc(10); chk("rst2_d1", 4'b1101, 7'b1000000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SCAN_DIV, default 1000: clock cycles per digit slot; legal range 4..65535.
REQ-002 BLANK_CYC, default 4: blanked cycles at the start of each slot (ghost guard); must be less than SCAN_DIV.
REQ-003 clk  input  1  sole clock; all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 digit_in  input  16  four BCD digits: [3:0] is digit 0 (least significant) through [15:12] is digit 3; fed by cascaded decade counters.
REQ-006 load  input  1  one-cycle strobe; captures digit_in.
REQ-007 blank_lz  input  1  leading-zero blanking enable.
REQ-008 dp_en  input  1  decimal-point enable.
REQ-009 dp_pos  input  2  digit index that carries the decimal point.
REQ-010 an  output  4  active-low, one-hot digit anode select.
REQ-011 seg  output  7  active-low cathodes; seg[0]=a through seg[6]=g.
REQ-012 dp  output  1  active-low decimal-point cathode.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each full 4-digit frame.

Function
REQ-014 The prescaler scan_cnt shall count 0..SCAN_DIV-1 and wrap to 0; the cycle where scan_cnt equals SCAN_DIV-1 is the slot boundary.
REQ-015 Digit index idx shall advance 0->1->2->3->0 on each slot boundary and shall hold at all other times.
REQ-016 On load, the block shall write digit_in into a shadow register on that edge.
REQ-017 The active display register shall update only on a slot boundary, taking the shadow value.
REQ-018 If load and a slot boundary coincide, the active register shall take digit_in directly (the new value wins).
REQ-019 Multiple loads within one slot: the last value shall win; no value is queued.
REQ-020 an, seg, dp and frame_done shall be registered outputs, computed from the same-cycle scan_cnt, idx and active register, so they appear one cycle later.
REQ-021 When scan_cnt < BLANK_CYC: an=4'b1111, seg=7'h7F, dp=1.
REQ-022 Otherwise, an shall drive the bit selected by idx low and the other three high.
REQ-023 Decode for codes 0-9 (seg[6:0] binary): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-024 Codes 10-15 shall display a dash: seg=0111111.
REQ-025 With blank_lz=1, digit k (k = 3, 2 or 1) shall output seg=7'h7F when digit k and all higher digits are zero; its anode shall still be driven.
REQ-026 Digit 0 shall never be blanked.
REQ-027 A dash code is nonzero and therefore stops leading-zero blanking.
REQ-028 dp shall be 0 only when dp_en=1, idx==dp_pos and the slot is outside the blank window.
REQ-029 dp shall not be suppressed by leading-zero blanking.
REQ-030 frame_done shall be 1 for exactly the one cycle after the slot boundary where idx goes 3->0.
REQ-031 The state machine shall have no deadlock: every idx value is left within SCAN_DIV cycles for any input sequence.

Reset
REQ-032 While rst=1 at an edge: scan_cnt=0, idx=0, shadow=0, active=0, an=4'hF, seg=7'h7F, dp=1, frame_done=0.
REQ-033 rst shall override load.
REQ-034 A reset mid-slot shall restart scanning at digit 0 with a full blank window.
REQ-035 After reset deasserts, the first an low (4'b1110) shall appear BLANK_CYC+1 cycles later.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-036 Reset release, no load -> digit 0 shows "0" (seg=1000000), digits 1-3 also "0" with blank_lz=0; an sequence 1110,1101,1011,0111; each slot 8 cycles with its first 2 cycles showing an=1111.
REQ-037 load digit_in=16'h1234 mid-slot -> the current digit is unchanged until the boundary; the next slot shows its digit from 1234 (digit 0 = "4", seg=0011001); a full frame shows 4,3,2,1.
REQ-038 digit_in=16'h0050, blank_lz=1 -> digits 3 and 2 show seg=1111111, digit 1 = "5", digit 0 = "0"; with blank_lz=0 all four digits are lit.
REQ-039 digit_in=16'h00A0 -> digit 1 shows seg=0111111; digit 0 = "0"; digits 3 and 2 are blanked.
REQ-040 dp_en=1, dp_pos=2 -> dp=0 only during the unblanked cycles of the idx=2 slot; frame_done pulses once every 32 cycles.
REQ-041 load asserted on a boundary cycle with 16'h9999, then rst asserted 3 cycles later -> the next slot shows "9"; after rst all outputs return to their REQ-032 values and the scan restarts at idx 0.
